// File: rtl/i2c_master.sv
// Single-master I2C writer: each accepted start pulse issues one fixed register write
// (address, register, data). SCL is push-pull; SDA is open-drain, only ever pulled low.
module i2c_master #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned SCL_FREQ = 100_000,
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter logic [7:0]  REG_ADDR = 8'h00,
    parameter logic [7:0]  WR_DATA  = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    inout  wire  SDA,
    output logic SCL
);

    localparam int unsigned   QTR      = CLK_FREQ / (4 * SCL_FREQ);
    localparam int unsigned   CW       = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] QTR_LAST = CW'(QTR - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK1, REG, ACK2, DATA, ACK3, STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          ack_q, ack_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;
    logic          tick;
    logic          slot_end;

    assign tick     = (qcnt_q == QTR_LAST);
    assign slot_end = tick && (quarter_q == 2'd3);

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        ack_d     = ack_q;

        if (state_q == IDLE) begin
            qcnt_d    = '0;
            quarter_d = 2'd0;
            bit_d     = 3'd0;
            if (start) begin
                state_d = START;
            end
        end else begin
            qcnt_d = tick ? '0 : qcnt_q + CW'(1);
            if (tick) begin
                quarter_d = quarter_q + 2'd1;
            end
        end

        case (state_q)
            START: begin
                if (slot_end) begin
                    state_d = ADDR;
                    shift_d = {DEV_ADDR, 1'b0};
                    bit_d   = 3'd0;
                end
            end
            ADDR, REG, DATA: begin
                if (slot_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = (state_q == ADDR) ? ACK1 : (state_q == REG) ? ACK2 : ACK3;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            ACK1, ACK2, ACK3: begin
                // Sample on the last clock of the first SCL-high quarter
                if (tick && (quarter_q == 2'd2)) begin
                    ack_d = (SDA == 1'b0);
                end
                if (slot_end) begin
                    // Unknown/undriven SDA falls through to STOP, same as NACK
                    if (ack_q && (state_q != ACK3)) begin
                        state_d = (state_q == ACK1) ? REG : DATA;
                        shift_d = (state_q == ACK1) ? REG_ADDR : WR_DATA;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (slot_end) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
    end

    // Bus levels are registered from the upcoming state so they change on slot boundaries
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            START: sda_oe_d = quarter_d[1];
            ADDR, REG, DATA: begin
                scl_d    = quarter_d[1];
                sda_oe_d = ~shift_d[7];
            end
            ACK1, ACK2, ACK3: scl_d = quarter_d[1];
            STOP: begin
                scl_d    = (quarter_d != 2'd0);
                sda_oe_d = ~quarter_d[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            quarter_q <= 2'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            ack_q     <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            ack_q     <= ack_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign SDA = sda_oe_q ? 1'b0 : 1'bz;
    assign SCL = scl_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: a bus monitor/slave decodes the wire activity and each scenario
// compares it with counts, bytes and durations derived from the transaction rules.
module tb_i2c_master;

    localparam int CLK_FREQ   = 4_000_000;
    localparam int SCL_FREQ   = 100_000;
    localparam int QTR        = CLK_FREQ / (4 * SCL_FREQ);
    localparam int SLOT       = 4 * QTR;
    localparam int TXN_BUDGET = 40 * SLOT;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic slave_drive = 1'b0;
    wire  SDA;
    wire  SCL;

    pullup (SDA);
    assign SDA = slave_drive ? 1'b0 : 1'bz;

    i2c_master #(
        .CLK_FREQ(CLK_FREQ),
        .SCL_FREQ(SCL_FREQ),
        .DEV_ADDR(7'h50),
        .REG_ADDR(8'h00),
        .WR_DATA (8'hA5)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .SDA  (SDA),
        .SCL  (SCL)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_bytes [3] = '{8'hA0, 8'h00, 8'hA5};

    // Monitor / slave state
    logic       mon_clr  = 1'b0;
    logic [2:0] ack_mask = 3'b000;
    int start_cnt, stop_cnt, illegal_cnt, timing_err, rises, nbits, byte_idx;
    int start_fall_cyc, stop_rise_cyc, rise_cyc, fall_cyc, low_len;
    bit in_txn, have_low, valid_rise, valid_fall;
    logic scl_p = 1'b1;
    logic sda_p = 1'b1;
    logic [7:0] sh;
    logic [7:0] bytes_q[$];
    logic       ack_bits[$];

    always @(negedge clk) begin
        logic s, d;
        s = SCL;
        d = SDA;
        if (mon_clr || !rst) begin
            if (mon_clr) begin
                start_cnt = 0; stop_cnt = 0; illegal_cnt = 0; timing_err = 0; rises = 0;
                bytes_q.delete();
                ack_bits.delete();
            end
            slave_drive = 1'b0;
            nbits = 0; byte_idx = 0;
            in_txn = 0; have_low = 0; valid_rise = 0; valid_fall = 0;
        end else begin
            if (scl_p && s && (sda_p !== d)) begin
                have_low = 0; valid_rise = 0; valid_fall = 0;
                if (d === 1'b0) begin
                    if (in_txn) illegal_cnt++;
                    start_cnt++;
                    start_fall_cyc = cyc;
                    in_txn = 1; nbits = 0; byte_idx = 0; rises = 0;
                end else begin
                    // A legal STOP follows the rising SCL that ends the last ACK slot
                    if (!in_txn || nbits != 1) illegal_cnt++;
                    stop_cnt++;
                    stop_rise_cyc = cyc;
                    in_txn = 0;
                    slave_drive = 1'b0;
                end
            end
            if (!scl_p && s) begin
                rises++;
                nbits++;
                if (nbits <= 8) sh = {sh[6:0], d};
                if (nbits == 8) bytes_q.push_back(sh);
                if (nbits == 9) ack_bits.push_back(d);
                if (valid_fall) begin
                    low_len  = cyc - fall_cyc;
                    have_low = 1;
                end
                rise_cyc   = cyc;
                valid_rise = 1;
            end
            if (scl_p && !s) begin
                if (have_low && low_len != 2 * QTR) timing_err++;
                if (valid_rise && (cyc - rise_cyc) != 2 * QTR) timing_err++;
                have_low   = 0;
                valid_rise = 0;
                fall_cyc   = cyc;
                valid_fall = in_txn;
                if (nbits == 8 && byte_idx < 3) begin
                    slave_drive = ack_mask[byte_idx];
                end else if (nbits == 9) begin
                    slave_drive = 1'b0;
                    nbits = 0;
                    byte_idx++;
                end
            end
        end
        scl_p = s;
        sda_p = d;
    end

    // Bytes that reach the wire: up to and including the first NACKed one
    function automatic int sent_bytes(input logic [2:0] m);
        int n = 1;
        while (n < 3 && m[n-1]) n++;
        return n;
    endfunction

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start(output int t0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_stop(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TXN_BUDGET; i++) begin
            @(negedge clk);
            if (stop_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3 * QTR) @(negedge clk);
    endtask

    task automatic test_reset();
        int badcyc;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (SCL !== 1'b1 || SDA !== 1'b1) begin
            bad++;
            $display("FAIL reset_hold: SCL=%b SDA=%b required 1/1", SCL, SDA);
        end
        clear_mon();
        rst = 1'b1;
        badcyc = 0;
        repeat (1000) begin
            @(negedge clk);
            if (SCL !== 1'b1 || SDA !== 1'b1) badcyc++;
        end
        total++;
        if (badcyc !== 0) begin
            bad++;
            $display("FAIL idle_bus: %0d cycles not high, required 0", badcyc);
        end
        total++;
        if (start_cnt !== 0) begin
            bad++;
            $display("FAIL idle_no_start: starts=%0d required 0", start_cnt);
        end
    endtask

    task automatic test_first_start();
        int t0;
        bit ok;
        ack_mask = 3'b111;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        clear_mon();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        wait_stop(1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL first_timeout: got no STOP, required STOP"); end
        total++;
        if ((start_fall_cyc - t0) !== 2 * QTR) begin
            bad++;
            $display("FAIL first_latency: got %0d required %0d", start_fall_cyc - t0, 2 * QTR);
        end
        total++;
        if (bytes_q.size() !== 3) begin
            bad++;
            $display("FAIL first_bytes: got %0d bytes required 3", bytes_q.size());
        end
    endtask

    task automatic test_ack_patterns(input int n);
        int t0, nsent;
        bit ok;
        logic [2:0] m;
        for (int it = 0; it < n; it++) begin
            m = (it == 0) ? 3'b111 : (it == 1) ? 3'b000 : 3'($urandom_range(0, 7));
            ack_mask = m;
            clear_mon();
            pulse_start(t0);
            wait_stop(1, ok);
            nsent = sent_bytes(m);
            total++;
            if (!ok) begin bad++; $display("FAIL pat_timeout: mask=%b no STOP", m); end
            total++;
            if (start_cnt !== 1 || stop_cnt !== 1) begin
                bad++;
                $display("FAIL pat_pairs: mask=%b start=%0d stop=%0d required 1/1",
                         m, start_cnt, stop_cnt);
            end
            total++;
            if (bytes_q.size() !== nsent) begin
                bad++;
                $display("FAIL pat_nbytes: mask=%b got %0d required %0d", m, bytes_q.size(), nsent);
            end
            for (int i = 0; i < nsent && i < bytes_q.size(); i++) begin
                total++;
                if (bytes_q[i] !== exp_bytes[i]) begin
                    bad++;
                    $display("FAIL pat_byte%0d: got %h required %h", i, bytes_q[i], exp_bytes[i]);
                end
            end
            for (int i = 0; i < nsent && i < ack_bits.size(); i++) begin
                total++;
                if (ack_bits[i] !== ~m[i]) begin
                    bad++;
                    $display("FAIL pat_ack%0d: got %b required %b", i, ack_bits[i], ~m[i]);
                end
            end
            total++;
            if (rises !== 9 * nsent + 1) begin
                bad++;
                $display("FAIL pat_slots: mask=%b got %0d SCL rises required %0d",
                         m, rises, 9 * nsent + 1);
            end
            total++;
            if ((start_fall_cyc - t0) !== 2 * QTR) begin
                bad++;
                $display("FAIL pat_latency: got %0d required %0d", start_fall_cyc - t0, 2 * QTR);
            end
            total++;
            if ((stop_rise_cyc - start_fall_cyc) !== 4 * QTR * (1 + 9 * nsent)) begin
                bad++;
                $display("FAIL pat_length: mask=%b got %0d required %0d", m,
                         stop_rise_cyc - start_fall_cyc, 4 * QTR * (1 + 9 * nsent));
            end
            total++;
            if (illegal_cnt !== 0 || timing_err !== 0) begin
                bad++;
                $display("FAIL pat_bus: illegal=%0d timing=%0d required 0/0",
                         illegal_cnt, timing_err);
            end
        end
    endtask

    task automatic test_ignore_start();
        int t0;
        bit ok;
        ack_mask = 3'b111;
        clear_mon();
        pulse_start(t0);
        repeat ($urandom_range(3, 100 * QTR)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_stop(1, ok);
        repeat (4 * SLOT) @(negedge clk);
        total++;
        if (!ok) begin bad++; $display("FAIL ign_timeout: got no STOP, required STOP"); end
        total++;
        if (start_cnt !== 1 || stop_cnt !== 1) begin
            bad++;
            $display("FAIL ign_pairs: start=%0d stop=%0d required 1/1", start_cnt, stop_cnt);
        end
        total++;
        if (bytes_q.size() !== 3) begin
            bad++;
            $display("FAIL ign_bytes: got %0d required 3", bytes_q.size());
        end
        total++;
        if ((stop_rise_cyc - start_fall_cyc) !== 112 * QTR) begin
            bad++;
            $display("FAIL ign_length: got %0d required %0d",
                     stop_rise_cyc - start_fall_cyc, 112 * QTR);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        bit ok, got;
        ack_mask = 3'b111;
        clear_mon();
        pulse_start(t0);
        got = 1'b0;
        for (int i = 0; i < TXN_BUDGET; i++) begin
            @(negedge clk);
            if (bytes_q.size() >= 2) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        if (!got) begin bad++; $display("FAIL mid_reach: REG byte not seen, required seen"); end
        // REG byte just completed: DATA spans roughly 1.5 to 9.5 slots from here
        repeat (2 * SLOT + $urandom_range(0, 5 * SLOT)) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (SCL !== 1'b1 || SDA !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_bus: SCL=%b SDA=%b required 1/1", SCL, SDA);
        end
        total++;
        if (bytes_q.size() !== 2) begin
            bad++;
            $display("FAIL mid_reset_point: got %0d bytes required 2", bytes_q.size());
        end
        repeat (2) @(negedge clk);
        clear_mon();
        rst = 1'b1;
        pulse_start(t0);
        wait_stop(1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL mid_timeout: got no STOP, required STOP"); end
        total++;
        if (bytes_q.size() !== 3) begin
            bad++;
            $display("FAIL mid_bytes: got %0d required 3", bytes_q.size());
        end else begin
            total++;
            if (bytes_q[2] !== 8'hA5) begin
                bad++;
                $display("FAIL mid_data: got %h required a5", bytes_q[2]);
            end
        end
        total++;
        if (start_cnt !== 1 || stop_cnt !== 1 || illegal_cnt !== 0 || timing_err !== 0) begin
            bad++;
            $display("FAIL mid_bus: start=%0d stop=%0d illegal=%0d timing=%0d required 1/1/0/0",
                     start_cnt, stop_cnt, illegal_cnt, timing_err);
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        bit ok1, ok2;
        ack_mask = 3'b111;
        clear_mon();
        pulse_start(t0);
        wait_stop(1, ok1);
        pulse_start(t1);
        wait_stop(2, ok2);
        total++;
        if (!(ok1 && ok2)) begin bad++; $display("FAIL b2b_timeout: ok=%b%b required 11", ok1, ok2); end
        total++;
        if (start_cnt !== 2 || stop_cnt !== 2) begin
            bad++;
            $display("FAIL b2b_pairs: start=%0d stop=%0d required 2/2", start_cnt, stop_cnt);
        end
        total++;
        if (bytes_q.size() !== 6) begin
            bad++;
            $display("FAIL b2b_nbytes: got %0d required 6", bytes_q.size());
        end
        for (int i = 0; i < bytes_q.size() && i < 6; i++) begin
            total++;
            if (bytes_q[i] !== exp_bytes[i % 3]) begin
                bad++;
                $display("FAIL b2b_byte%0d: got %h required %h", i, bytes_q[i], exp_bytes[i % 3]);
            end
        end
        total++;
        if ((start_fall_cyc - t1) !== 2 * QTR) begin
            bad++;
            $display("FAIL b2b_latency: got %0d required %0d", start_fall_cyc - t1, 2 * QTR);
        end
        total++;
        if (illegal_cnt !== 0 || timing_err !== 0) begin
            bad++;
            $display("FAIL b2b_bus: illegal=%0d timing=%0d required 0/0", illegal_cnt, timing_err);
        end
    endtask

    initial begin
        test_reset();
        test_first_start();
        test_ack_patterns(8);
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000: system clock frequency in Hz.
REQ-002 Parameter SCL_FREQ, default 100_000: bus bit rate in Hz; QTR = CLK_FREQ/(4*SCL_FREQ) clocks, 250 with the defaults.
REQ-003 Parameter DEV_ADDR, default 7'h50: 7-bit target address.
REQ-004 Parameter REG_ADDR, default 8'h00: register byte sent after the address.
REQ-005 Parameter WR_DATA, default 8'hA5: data byte written.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-low.
REQ-008 start  input  1  synchronous request pulse; one cycle high launches one write transaction.
REQ-009 SDA  inout  1  open-drain data line; driven only 0 or Z, external pull-up.
REQ-010 SCL  output  1  push-pull bus clock; single master, no clock stretching.

Function
REQ-011 The SHALL-level transaction is: START, address byte {DEV_ADDR,1'b0}, ACK, REG_ADDR, ACK, WR_DATA, ACK, STOP.
REQ-012 The FSM SHALL have states IDLE, START, ADDR, ACK1, REG, ACK2, DATA, ACK3, STOP, and SHALL return to IDLE after STOP.
REQ-013 start SHALL be sampled only in IDLE; start pulses in any other state SHALL be ignored.
REQ-014 A quarter-period counter SHALL count 0..QTR-1; each bit slot SHALL be 4 quarters: Q0 SCL=0 and SDA updated at entry; Q1 SCL=0; Q2 SCL=1; Q3 SCL=1.
REQ-015 START SHALL hold SCL=1 and SDA released for 2 quarters, then SDA=0 with SCL=1 for 2 quarters, then enter ADDR with SCL falling.
REQ-016 Bytes SHALL be shifted MSB first, 8 bit slots each; SDA SHALL change only while SCL=0.
REQ-017 In ACK states the master SHALL release SDA for one bit slot and sample it at the last clock of Q2.
REQ-018 A sampled 0 SHALL mean ACK and advance the FSM; a sampled 1 or Z SHALL mean NACK and go directly to STOP.
REQ-019 STOP SHALL drive SDA=0 with SCL=0 for 1 quarter, SCL=1 with SDA=0 for 1 quarter, then release SDA with SCL=1 for 2 quarters.
REQ-020 In IDLE, SCL SHALL be 1 and SDA SHALL be released.
REQ-021 With the defaults and all ACKs, START to the end of STOP SHALL take 29 bit slots = 29*4*QTR clocks (290 us at 100 MHz).

Reset
REQ-022 Reset SHALL force IDLE, SCL=1, SDA released, clear the counters and the shift register, and abort any transaction immediately.
REQ-023 The first start SHALL be accepted on the first clock edge after rst deasserts.

Verification
REQ-024 rst=0 for 5 clocks, then release with no start -> SCL=1 and SDA=Z/pulled high for 1000 clocks.
REQ-025 Pull-ups fitted, slave model ACKs, start pulse at cycle 25 -> SDA falls while SCL=1, decoded bytes 0xA0, 0x00, 0xA5, STOP observed, IDLE about 29000 clocks later.
REQ-026 No slave fitted (SDA pulled high) -> NACK at ACK1, STOP after exactly 9 bit slots, no REG byte sent.
REQ-027 Second start pulse mid-transaction -> ignored; exactly one START/STOP pair observed.
REQ-028 Assert rst during the DATA byte -> SCL=1 and SDA released on the next clock; a new start afterwards produces a full transaction.
REQ-029 Bus monitor -> no SDA transition while SCL=1 except at START and STOP, and each SCL high and low time equals 2*QTR clocks.
